sim_mailbox: RTL and testbench

Snoop-and-report stage on the 64-bit RAM port, downstream of `spartan2ram` and alongside `axi_ram`. It decodes CPU writes to the four simulation mailbox words at the top of the address space (info, warn, pass, fail) and queues them in a small event FIFO. It runs a pass/fail/timeout state machine with a post-verdict drain window and exposes a registered verdict and cycle count to the bench.

---
 rtl/sim_mailbox_if.sv | 22 ++
 rtl/sim_mailbox.sv | 206 ++++++++++++++++++++
 tb/tb_sim_mailbox.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sim_mailbox_if.sv
// RAM write port and event-stream handshake shared by the CPU side and sim_mailbox.
interface sim_mailbox_if;
    logic        CS;
    logic        WR;
    logic [31:0] ADDR;
    logic [63:0] MASK;
    logic [63:0] DIN;
    logic        EV_VLD;
    logic        EV_RDY;
    logic [1:0]  EV_KIND;
    logic [31:0] EV_DATA;

    modport master (
        output CS, WR, ADDR, MASK, DIN, EV_RDY,
        input  EV_VLD, EV_KIND, EV_DATA
    );

    modport slave (
        input  CS, WR, ADDR, MASK, DIN, EV_RDY,
        output EV_VLD, EV_KIND, EV_DATA
    );
endinterface

// File: rtl/sim_mailbox.sv
// Snoops CPU writes to the 16-byte mailbox window, queues them as events and runs the
// pass/fail/timeout verdict FSM. Console reporting is enabled by SIM_MAILBOX_DISPLAY_EN.
module sim_mailbox #(
    parameter logic [31:0] MAGIC_BASE   = 32'hFFFF_FFF0,
    parameter logic [31:0] MAX_CLOCKS   = 32'd100000,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          DRAIN_CYCLES = 4
) (
    input  logic         sim_clk,
    input  logic         sim_rst,
    sim_mailbox_if.slave bus,
    output logic [7:0]   DROPS,
    output logic [31:0]  CYCLES,
    output logic         PASS,
    output logic         FAIL,
    output logic         TIMEOUT,
    output logic         DONE
);
    localparam int         AW         = $clog2(FIFO_DEPTH);
    localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES);
    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t       state_r, state_s;
    logic [33:0]  mem_r [FIFO_DEPTH];
    logic [AW:0]  wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
    logic         ev_vld_r, head_vld_s;
    logic [33:0]  head_r, head_s;
    logic [7:0]   drops_r, drops_s, drain_r, drain_s;
    logic [31:0]  cycles_r, cycles_s;
    logic         pass_r, fail_r, timeout_r, done_r;
    logic         pass_s, fail_s, timeout_s;
    logic         hit_s, full_s, pop_s, push_s, drop_s, verdict_hit_s;
    logic [1:0]   kind_s;
    logic         unused_s;

    assign unused_s    = ^{bus.MASK, bus.DIN[63:32]};
    assign bus.EV_VLD  = ev_vld_r;
    assign bus.EV_KIND = head_r[33:32];
    assign bus.EV_DATA = head_r[31:0];
    assign DROPS       = drops_r;
    assign CYCLES      = cycles_r;
    assign PASS        = pass_r;
    assign FAIL        = fail_r;
    assign TIMEOUT     = timeout_r;
    assign DONE        = done_r;

    // Mailbox address decode; DONE stops all further capture
    always_comb begin
        kind_s        = bus.ADDR[3:2];
        hit_s         = bus.CS && bus.WR && (bus.ADDR[31:4] == MAGIC_BASE[31:4]) &&
                        (bus.ADDR[1:0] == 2'b00) && (state_r != ST_DONE);
        verdict_hit_s = hit_s && kind_s[1];
    end

    // FIFO pointer update and next head; a push into a slot that becomes the head bypasses memory
    always_comb begin
        full_s = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        pop_s  = ev_vld_r && bus.EV_RDY;
        push_s = hit_s && (!full_s || pop_s);
        drop_s = hit_s && full_s && !pop_s;
        if (push_s) begin
            wr_ptr_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_s = rd_ptr_r;
        end
        if (wr_ptr_s == rd_ptr_s) begin
            head_vld_s = 1'b0;
            head_s     = 34'd0;
        end else if (push_s && (rd_ptr_s == wr_ptr_r)) begin
            head_vld_s = 1'b1;
            head_s     = {kind_s, bus.DIN[31:0]};
        end else begin
            head_vld_s = 1'b1;
            head_s     = mem_r[rd_ptr_s[AW-1:0]];
        end
        if (drop_s && (drops_r != 8'hFF)) begin
            drops_s = drops_r + 8'd1;
        end else begin
            drops_s = drops_r;
        end
    end

    // Verdict FSM next state; a verdict hit outranks a coincident watchdog expiry
    always_comb begin
        state_s   = state_r;
        drain_s   = drain_r;
        cycles_s  = cycles_r;
        pass_s    = pass_r;
        fail_s    = fail_r;
        timeout_s = timeout_r;
        case (state_r)
            ST_RUN: begin
                if (cycles_r != MAX_CLOCKS) begin
                    cycles_s = cycles_r + 32'd1;
                end else begin
                    cycles_s = cycles_r;
                end
                if (verdict_hit_s) begin
                    pass_s  = !kind_s[0];
                    fail_s  = kind_s[0];
                    drain_s = DRAIN_LOAD;
                    state_s = ST_DRAIN;
                end else if (cycles_r == MAX_CLOCKS) begin
                    timeout_s = 1'b1;
                    drain_s   = DRAIN_LOAD;
                    state_s   = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_r <= 8'd1) begin
                    drain_s = 8'd0;
                    state_s = ST_DONE;
                end else begin
                    drain_s = drain_r - 8'd1;
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_s = ST_DONE;
            end
            default: begin
                state_s = ST_RUN;
            end
        endcase
    end

    // FSM, verdict and counter registers
    always_ff @(posedge sim_clk or posedge sim_rst) begin
        if (sim_rst) begin
            state_r   <= ST_RUN;
            drain_r   <= 8'd0;
            cycles_r  <= 32'd0;
            pass_r    <= 1'b0;
            fail_r    <= 1'b0;
            timeout_r <= 1'b0;
            done_r    <= 1'b0;
            drops_r   <= 8'd0;
        end else begin
            state_r   <= state_s;
            drain_r   <= drain_s;
            cycles_r  <= cycles_s;
            pass_r    <= pass_s;
            fail_r    <= fail_s;
            timeout_r <= timeout_s;
            done_r    <= (state_s == ST_DONE);
            drops_r   <= drops_s;
        end
    end

    // Event storage, pointers and registered head
    always_ff @(posedge sim_clk or posedge sim_rst) begin
        if (sim_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 34'd0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            ev_vld_r <= 1'b0;
            head_r   <= 34'd0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= {kind_s, bus.DIN[31:0]};
            end
            wr_ptr_r <= wr_ptr_s;
            rd_ptr_r <= rd_ptr_s;
            ev_vld_r <= head_vld_s;
            head_r   <= head_s;
        end
    end

`ifdef SIM_MAILBOX_DISPLAY_EN
    // Console reporting and self-termination for simulation builds
    always_ff @(posedge sim_clk) begin
        if (!sim_rst) begin
            if (push_s) begin
                case (kind_s)
                    2'd0:    $display("### SIMULATION INFO - 0x%08X ###", bus.DIN[31:0]);
                    2'd1:    $display("### SIMULATION WARN - 0x%08X ###", bus.DIN[31:0]);
                    2'd2:    $display("### SIMULATION PASSED - 0x%08X ###", bus.DIN[31:0]);
                    default: $display("### SIMULATION FAILED - 0x%08X ###", bus.DIN[31:0]);
                endcase
            end
            if (timeout_s && !timeout_r) begin
                $display(" ****** MAX CLOCKS - ENDING SIMULATION *****");
            end
            if (done_r) begin
                $finish;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sim_mailbox.sv
// Self-checking bench for sim_mailbox: directed table, hand sequences and a randomized
// phase checked against a queue-based reference model.
module tb_sim_mailbox;
    localparam logic [31:0] MB    = 32'hFFFF_FFF0;
    localparam logic [31:0] MAXC  = 32'd50;
    localparam int          DEPTH = 8;
    localparam int          DRAIN = 4;

    logic        sim_clk = 1'b0;
    logic        sim_rst = 1'b1;
    logic [7:0]  drops;
    logic [31:0] cycles;
    logic        pass, fail, timeout, done;
    int          tests = 0;
    int          fails = 0;

    sim_mailbox_if mb ();

    sim_mailbox #(.MAGIC_BASE(MB), .MAX_CLOCKS(MAXC), .FIFO_DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN)) dut (
        .sim_clk(sim_clk), .sim_rst(sim_rst), .bus(mb),
        .DROPS(drops), .CYCLES(cycles), .PASS(pass), .FAIL(fail), .TIMEOUT(timeout), .DONE(done)
    );

    always #5 sim_clk = ~sim_clk;

    // Reference model: event queue plus edge bookkeeping
    typedef struct { logic [1:0] k; logic [31:0] d; } ev_t;
    ev_t         q[$];
    int          m_drops, m_edge, m_vedge;
    logic [31:0] m_cycles;
    bit          m_pass, m_fail, m_tmo, m_done;

    typedef struct {
        logic cs; logic wr; logic [31:0] addr; logic [31:0] din; logic rdy;
        logic vld; logic [1:0] kind; logic [31:0] data; logic [7:0] drops; logic pass; logic fail;
    } vec_t;

    function void chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic drive(logic cs, logic wr, logic [31:0] addr, logic [31:0] din, logic rdy);
        mb.CS = cs; mb.WR = wr; mb.ADDR = addr; mb.MASK = 64'hFFFF_FFFF_FFFF_FFFF;
        mb.DIN = {32'hA5A5_5A5A, din}; mb.EV_RDY = rdy;
    endtask

    task automatic tick();
        @(posedge sim_clk);
        #1;
    endtask

    function void m_reset();
        q.delete();
        m_drops = 0; m_edge = 0; m_vedge = 0; m_cycles = 32'd0;
        m_pass = 1'b0; m_fail = 1'b0; m_tmo = 1'b0; m_done = 1'b0;
    endfunction

    task automatic do_reset();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        sim_rst = 1'b1;
        repeat (2) @(posedge sim_clk);
        #1;
        sim_rst = 1'b0;
        m_reset();
    endtask

    function void m_step(logic cs, logic wr, logic [31:0] addr, logic [31:0] din, logic rdy);
        bit hit, decided;
        m_edge++;
        hit = cs && wr && (addr[31:4] == MB[31:4]) && (addr[1:0] == 2'b00) && !m_done;
        if (rdy && q.size() > 0) void'(q.pop_front());
        if (hit) begin
            if (q.size() < DEPTH) q.push_back('{addr[3:2], din});
            else if (m_drops < 255) m_drops++;
        end
        decided = m_pass || m_fail || m_tmo;
        if (!decided) begin
            if (hit && addr[3]) begin
                if (addr[2]) m_fail = 1'b1; else m_pass = 1'b1;
                m_vedge = m_edge;
            end else if (m_cycles == MAXC) begin
                m_tmo = 1'b1;
                m_vedge = m_edge;
            end
            if (m_cycles < MAXC) m_cycles++;
        end else if (m_edge == m_vedge + DRAIN) begin
            m_done = 1'b1;
        end
    endfunction

    function void m_compare();
        chk("rnd_vld", mb.EV_VLD, (q.size() > 0));
        if (q.size() > 0) begin
            chk("rnd_kind", mb.EV_KIND, q[0].k);
            chk("rnd_data", mb.EV_DATA, q[0].d);
        end
        chk("rnd_drops", drops, m_drops);
        chk("rnd_cycles", cycles, m_cycles);
        chk("rnd_pass", pass, m_pass);
        chk("rnd_fail", fail, m_fail);
        chk("rnd_timeout", timeout, m_tmo);
        chk("rnd_done", done, m_done);
    endfunction

    initial begin
        vec_t vecs[10];
        vecs[0] = '{1'b1, 1'b1, 32'hFFFF_FFF0, 32'h11, 1'b0, 1'b1, 2'd0, 32'h11, 8'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'hFFFF_FFF4, 32'h22, 1'b0, 1'b1, 2'd0, 32'h11, 8'd0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 32'h0,         32'h0,  1'b1, 1'b1, 2'd1, 32'h22, 8'd0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h0,         32'h0,  1'b1, 1'b0, 2'd0, 32'h0,  8'd0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 32'hFFFF_FFE0, 32'h5,  1'b0, 1'b0, 2'd0, 32'h0,  8'd0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'h6,  1'b0, 1'b0, 2'd0, 32'h0,  8'd0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 32'hFFFF_FFF8, 32'h7,  1'b0, 1'b0, 2'd0, 32'h0,  8'd0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 32'hFFFF_FFF0, 32'h33, 1'b1, 1'b1, 2'd0, 32'h33, 8'd0, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 32'hFFFF_FFF4, 32'h44, 1'b1, 1'b1, 2'd1, 32'h44, 8'd0, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 32'h0,         32'h0,  1'b1, 1'b0, 2'd0, 32'h0,  8'd0, 1'b0, 1'b0};

        do_reset();
        chk("rst_vld", mb.EV_VLD, 1'b0); chk("rst_kind", mb.EV_KIND, 2'd0);
        chk("rst_data", mb.EV_DATA, 32'd0); chk("rst_cycles", cycles, 32'd0);
        chk("rst_flags", {drops, pass, fail, timeout, done}, 12'd0);

        // Directed table: ordering, decode rejects, pop/push overlap
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].cs, vecs[i].wr, vecs[i].addr, vecs[i].din, vecs[i].rdy);
            tick();
            chk($sformatf("tbl%0d_vld", i), mb.EV_VLD, vecs[i].vld);
            if (vecs[i].vld) begin
                chk($sformatf("tbl%0d_kind", i), mb.EV_KIND, vecs[i].kind);
                chk($sformatf("tbl%0d_data", i), mb.EV_DATA, vecs[i].data);
            end
            chk($sformatf("tbl%0d_drops", i), drops, vecs[i].drops);
            chk($sformatf("tbl%0d_verdict", i), {pass, fail}, {vecs[i].pass, vecs[i].fail});
        end

        // Pass verdict, later fail queued but ignored, drain window
        do_reset();
        drive(1'b1, 1'b1, 32'hFFFF_FFF8, 32'hCAFE, 1'b0); tick();
        chk("pass_set", pass, 1'b1); chk("pass_done0", done, 1'b0); chk("pass_cyc", cycles, 32'd1);
        chk("pass_kind", mb.EV_KIND, 2'd2); chk("pass_data", mb.EV_DATA, 32'hCAFE);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0); tick();
        drive(1'b1, 1'b1, 32'hFFFF_FFFC, 32'hDEAD, 1'b0); tick();
        chk("late_fail", fail, 1'b0);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0); tick();
        chk("drain_done0", done, 1'b0);
        tick();
        chk("drain_done1", done, 1'b1); chk("drain_cyc", cycles, 32'd1);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1); tick();
        chk("late_vld", mb.EV_VLD, 1'b1); chk("late_kind", mb.EV_KIND, 2'd3);
        chk("late_data", mb.EV_DATA, 32'hDEAD);
        tick();
        chk("late_empty", mb.EV_VLD, 1'b0);

        // Full FIFO: ten infos then a fail, consumer stalled
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 32'hFFFF_FFF0, i + 1, 1'b0); tick();
        end
        drive(1'b1, 1'b1, 32'hFFFF_FFFC, 32'hDEAD, 1'b0); tick();
        chk("full_drops", drops, 8'd3); chk("full_fail", fail, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("full_vld%0d", i), mb.EV_VLD, 1'b1);
            chk($sformatf("full_data%0d", i), mb.EV_DATA, i + 1);
            drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1); tick();
        end
        chk("full_empty", mb.EV_VLD, 1'b0);

        // Watchdog expiry
        do_reset();
        repeat (50) tick();
        chk("wd_cyc50", cycles, 32'd50); chk("wd_tmo0", timeout, 1'b0);
        tick();
        chk("wd_tmo1", timeout, 1'b1); chk("wd_freeze", cycles, 32'd50);
        repeat (3) tick();
        chk("wd_done0", done, 1'b0);
        tick();
        chk("wd_done1", done, 1'b1); chk("wd_freeze2", cycles, 32'd50);

        // Verdict coinciding with expiry
        do_reset();
        repeat (50) tick();
        drive(1'b1, 1'b1, 32'hFFFF_FFF8, 32'h1, 1'b0); tick();
        chk("coin_pass", pass, 1'b1); chk("coin_tmo", timeout, 1'b0); chk("coin_cyc", cycles, 32'd50);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0); repeat (4) tick();
        chk("coin_done", done, 1'b1); chk("coin_tmo2", timeout, 1'b0);

        // Asynchronous reset during DRAIN with queued events
        do_reset();
        drive(1'b1, 1'b1, 32'hFFFF_FFF0, 32'h1, 1'b0); tick();
        drive(1'b1, 1'b1, 32'hFFFF_FFF4, 32'h2, 1'b0); tick();
        drive(1'b1, 1'b1, 32'hFFFF_FFF8, 32'h3, 1'b0); tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0); tick();
        #3 sim_rst = 1'b1;
        #1;
        chk("arst_vld", mb.EV_VLD, 1'b0); chk("arst_head", {mb.EV_KIND, mb.EV_DATA}, 34'd0);
        chk("arst_cyc", cycles, 32'd0);
        chk("arst_flags", {drops, pass, fail, timeout, done}, 12'd0);
        @(posedge sim_clk); #1; sim_rst = 1'b0;
        repeat (3) tick();
        chk("arst_restart", cycles, 32'd3); chk("arst_vld2", mb.EV_VLD, 1'b0);
        drive(1'b1, 1'b1, 32'hFFFF_FFF4, 32'h9, 1'b0); tick();
        chk("arst_run", mb.EV_VLD, 1'b1);

        // Randomized traffic against the reference model
        for (int run = 0; run < 4; run++) begin
            do_reset();
            for (int c = 0; c < 110; c++) begin
                logic cs, wr, rdy;
                logic [31:0] addr, din;
                int r;
                cs  = ($urandom_range(0, 3) != 0);
                wr  = ($urandom_range(0, 2) != 0);
                rdy = ($urandom_range(0, 2) == 0);
                din = $urandom;
                r   = $urandom_range(0, 63);
                if (r == 0 && run != 1)      addr = 32'hFFFF_FFF8;
                else if (r == 1 && run != 1) addr = 32'hFFFF_FFFC;
                else if (r < 30)             addr = 32'hFFFF_FFF0;
                else if (r < 55)             addr = 32'hFFFF_FFF4;
                else if (r < 58)             addr = 32'hFFFF_FFF0 | $urandom_range(1, 3);
                else if (r < 61)             addr = 32'hFFFF_FFE4;
                else                         addr = $urandom & 32'hFFFF_FFF3;
                drive(cs, wr, addr, din, rdy);
                m_step(cs, wr, addr, din, rdy);
                tick();
                m_compare();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
